// File: rtl/jesd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_pkg
//  Description : Shared types and constants for the JESD204B transmit
//                link-layer sequencer (link-state encoding, ILAS config
//                multiframe index, error-counter width, saturating helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package jesd_pkg;

  // Link-layer state; the encoding is visible on o_state
  typedef enum logic [1:0] {
    ST_CGS       = 2'd0,
    ST_WAIT_LMFC = 2'd1,
    ST_ILAS      = 2'd2,
    ST_DATA      = 2'd3
  } link_state_e;

  // ILAS multiframe that carries the link configuration data
  localparam logic [1:0] ILAS_CFG_MF_IDX = 2'd1;

  // Width of the optional error-report counter
  localparam int ERR_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jesd_sync_detect.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_sync_detect
//  Description : SYNC~ low-run counter. Counts frame pulses seen while SYNC~
//                is low, flags a resync request once the run reaches
//                RESYNC_FRAMES, and flags an error-report pulse when SYNC~
//                rises after a shorter, non-empty run.
//  Revision    : 1.0 - initial release
// ============================================================================
module jesd_sync_detect #(
  parameter int RESYNC_FRAMES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_i,
  input  logic sync_n_i,
  output logic resync_req_o,
  output logic err_pulse_o
);

  localparam logic [3:0] c_THRESH = 4'(RESYNC_FRAMES);

  logic [3:0] lowcnt_q;
  logic [3:0] lowcnt_d;

  // Next low-run count: any high SYNC~ clears it, a low frame pulse adds one
  always_comb begin
    lowcnt_d = lowcnt_q;
    if (sync_n_i) begin
      lowcnt_d = 4'd0;
    end else if (frame_i && (lowcnt_q < c_THRESH)) begin
      lowcnt_d = lowcnt_q + 4'd1;
    end
  end

  // Low-run counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lowcnt_q <= 4'd0;
    end else begin
      lowcnt_q <= lowcnt_d;
    end
  end

  // Request is raised on the very frame pulse that completes the run, so
  // the sequencer drops to CGS one cycle after that pulse.
  assign resync_req_o = !sync_n_i && (lowcnt_d == c_THRESH);

  // A non-zero count implies SYNC~ was low on the previous cycle, so a high
  // SYNC~ with a short run is exactly a rising edge ending a short pulse.
  assign err_pulse_o  = sync_n_i && (lowcnt_q != 4'd0) && (lowcnt_q < c_THRESH);

endmodule
`default_nettype wire

// File: rtl/jesd_tx_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jesd_tx_link_ctrl
//  Description : JESD204B transmit link-layer sequencer. Steps the lane
//                through CGS, WAIT_LMFC, ILAS and DATA from the frame/LMFC
//                pulses and the receiver's SYNC~, and reports SYNC~ error
//                pulses. All outputs are registered.
//                Optional feature macro: JESD_TX_ERR_CNT_EN adds the
//                saturating error-report counter output o_err_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module jesd_tx_link_ctrl
  import jesd_pkg::*;
#(
  parameter int ILAS_MF       = 4,
  parameter int RESYNC_FRAMES = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_clk,
  input  logic       i_lmfc_clk,
  input  logic       i_sync_n,
  output logic [1:0] o_state,
  output logic       o_cgs_en,
  output logic       o_ilas_en,
  output logic [1:0] o_ilas_mf_idx,
  output logic       o_ilas_cfg_mf,
  output logic       o_data_en,
  output logic       o_err_rpt
`ifdef JESD_TX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] o_err_cnt
`endif
);

  localparam logic [1:0] c_MF_LAST = 2'(ILAS_MF - 1);

  link_state_e state_q;
  link_state_e state_d;
  logic [1:0]  mf_idx_q;
  logic [1:0]  mf_idx_d;
  logic        err_d;
  logic        lmfc_prev_q;
  logic        lb;
  logic        resync_req;
  logic        err_pulse;

  jesd_sync_detect #(
    .RESYNC_FRAMES (RESYNC_FRAMES)
  ) u_sync_detect (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_i      (i_frame_clk),
    .sync_n_i     (i_sync_n),
    .resync_req_o (resync_req),
    .err_pulse_o  (err_pulse)
  );

  // LMFC rising-edge detect; resets high so a pulse already high at reset
  // release is not mistaken for a boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lmfc_prev_q <= 1'b1;
    end else begin
      lmfc_prev_q <= i_lmfc_clk;
    end
  end

  assign lb = i_lmfc_clk & ~lmfc_prev_q;

  // Next-state logic: resync beats an LMFC boundary, low SYNC~ in WAIT_LMFC
  // beats an LMFC boundary.
  always_comb begin
    state_d  = state_q;
    mf_idx_d = mf_idx_q;
    err_d    = 1'b0;
    case (state_q)
      ST_CGS: begin
        if (i_frame_clk && i_sync_n) begin
          state_d = ST_WAIT_LMFC;
        end
      end
      ST_WAIT_LMFC: begin
        if (!i_sync_n) begin
          state_d = ST_CGS;
        end else if (lb) begin
          state_d  = ST_ILAS;
          mf_idx_d = 2'd0;
        end
      end
      ST_ILAS: begin
        if (resync_req) begin
          state_d = ST_CGS;
        end else if (lb) begin
          if (mf_idx_q == c_MF_LAST) begin
            state_d = ST_DATA;
          end else begin
            mf_idx_d = mf_idx_q + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (resync_req) begin
          state_d = ST_CGS;
        end else if (err_pulse) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CGS;
      end
    endcase
    // The multiframe index is only meaningful in ILAS; park it at zero so a
    // later relink always restarts from the first multiframe.
    if (state_d != ST_ILAS) begin
      mf_idx_d = 2'd0;
    end
  end

  // State register and output decode, all registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_CGS;
      mf_idx_q      <= 2'd0;
      o_cgs_en      <= 1'b1;
      o_ilas_en     <= 1'b0;
      o_ilas_cfg_mf <= 1'b0;
      o_data_en     <= 1'b0;
      o_err_rpt     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mf_idx_q      <= mf_idx_d;
      o_cgs_en      <= (state_d == ST_CGS) || (state_d == ST_WAIT_LMFC);
      o_ilas_en     <= (state_d == ST_ILAS);
      o_ilas_cfg_mf <= (state_d == ST_ILAS) && (mf_idx_d == ILAS_CFG_MF_IDX);
      o_data_en     <= (state_d == ST_DATA);
      o_err_rpt     <= err_d;
    end
  end

  assign o_state       = state_q;
  assign o_ilas_mf_idx = mf_idx_q;

`ifdef JESD_TX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Error-report counter: cleared whenever the link falls back to CGS,
  // updated in step with o_err_rpt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (state_d == ST_CGS) begin
      err_cnt_q <= '0;
    end else if (err_d) begin
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jesd_tx_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jesd_tx_link_ctrl
//  Description : Self-checking bench for jesd_tx_link_ctrl: a directed
//                vector table, hand-written link sequences and a random
//                SYNC~ phase, all compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jesd_tx_link_ctrl;

  localparam int ILAS_MF       = 4;
  localparam int RESYNC_FRAMES = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_frame_clk;
  logic       i_lmfc_clk;
  logic       i_sync_n;
  logic [1:0] o_state;
  logic       o_cgs_en;
  logic       o_ilas_en;
  logic [1:0] o_ilas_mf_idx;
  logic       o_ilas_cfg_mf;
  logic       o_data_en;
  logic       o_err_rpt;
`ifdef JESD_TX_ERR_CNT_EN
  logic [7:0] o_err_cnt;
`endif

  always #5 clk = ~clk;

  jesd_tx_link_ctrl #(
    .ILAS_MF       (ILAS_MF),
    .RESYNC_FRAMES (RESYNC_FRAMES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_clk   (i_frame_clk),
    .i_lmfc_clk    (i_lmfc_clk),
    .i_sync_n      (i_sync_n),
    .o_state       (o_state),
    .o_cgs_en      (o_cgs_en),
    .o_ilas_en     (o_ilas_en),
    .o_ilas_mf_idx (o_ilas_mf_idx),
    .o_ilas_cfg_mf (o_ilas_cfg_mf),
    .o_data_en     (o_data_en),
    .o_err_rpt     (o_err_rpt)
`ifdef JESD_TX_ERR_CNT_EN
    ,
    .o_err_cnt     (o_err_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: state number, unbounded count of low frames,
  // multiframe index, last LMFC sample, error pulse and error count.
  int m_state = 0;
  int m_low   = 0;
  int m_mf    = 0;
  int m_cnt   = 0;
  bit m_prev  = 1'b1;
  bit m_err   = 1'b0;

  // Stimulus generator: frame every 2 clocks, LMFC every 8 clocks, 2 high
  int gcyc   = 0;
  bit sn_lvl = 1'b0;
  bit rn_lvl = 1'b0;

  typedef struct {
    bit fr; bit lm; bit sn; bit rn;
    int st; bit cgs; bit ilas; int mf; bit cfg; bit data; bit err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit fr, input bit lm, input bit sn, input bit rn);
    int  nxt;
    bit  lb;
    bit  resync;
    bit  errev;
    if (!rn) begin
      m_state = 0; m_low = 0; m_mf = 0; m_cnt = 0; m_prev = 1'b1; m_err = 1'b0;
      return;
    end
    lb     = lm && !m_prev;
    m_prev = lm;
    resync = !sn && ((m_low + int'(fr)) >= RESYNC_FRAMES);
    errev  = sn && (m_low >= 1) && (m_low < RESYNC_FRAMES);
    m_low  = sn ? 0 : m_low + int'(fr);
    m_err  = 1'b0;
    nxt    = m_state;
    case (m_state)
      0: if (fr && sn) nxt = 1;
      1: if (!sn) nxt = 0; else if (lb) begin nxt = 2; m_mf = 0; end
      2: if (resync) nxt = 0;
         else if (lb) begin
           if (m_mf == ILAS_MF - 1) nxt = 3; else m_mf++;
         end
      default: if (resync) nxt = 0; else if (errev) m_err = 1'b1;
    endcase
    if (nxt != 2) m_mf = 0;
    if (nxt == 0) m_cnt = 0;
    else if (m_err && m_cnt < 255) m_cnt++;
    m_state = nxt;
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input bit fr, input bit lm, input bit sn, input bit rn);
    i_frame_clk = fr;
    i_lmfc_clk  = lm;
    i_sync_n    = sn;
    rst_n       = rn;
    @(posedge clk);
    model_update(fr, lm, sn, rn);
    #1;
    chk("state",    o_state,       m_state);
    chk("cgs_en",   o_cgs_en,      m_state <= 1);
    chk("ilas_en",  o_ilas_en,     m_state == 2);
    chk("mf_idx",   o_ilas_mf_idx, m_mf);
    chk("cfg_mf",   o_ilas_cfg_mf, (m_state == 2) && (m_mf == 1));
    chk("data_en",  o_data_en,     m_state == 3);
    chk("err_rpt",  o_err_rpt,     m_err);
`ifdef JESD_TX_ERR_CNT_EN
    chk("err_cnt",  o_err_cnt,     m_cnt);
`endif
  endtask

  task automatic gen_step();
    bit fr;
    bit lm;
    fr = (gcyc % 2) == 0;
    lm = (gcyc % 8) < 2;
    step(fr, lm, sn_lvl, rn_lvl);
    gcyc++;
  endtask

  // Step until n frame pulses have been applied
  task automatic gen_frames(input int n);
    int f;
    bit fr;
    f = 0;
    while (f < n) begin
      fr = (gcyc % 2) == 0;
      gen_step();
      if (fr) f++;
    end
  endtask

  // Step until o_state reaches target, bounded by budget cycles
  task automatic run_until(input int target, input int budget, input string name, output int n);
    n = 0;
    while ((o_state !== 2'(target)) && (n < budget)) begin
      gen_step();
      n++;
    end
    chk(name, o_state, target);
  endtask

  task automatic add(input bit fr, input bit lm, input bit sn, input bit rn,
                     input int st, input bit cgs, input bit ilas, input int mf,
                     input bit cfg, input bit data, input bit err);
    vec_t v;
    v.fr = fr; v.lm = lm; v.sn = sn; v.rn = rn;
    v.st = st; v.cgs = cgs; v.ilas = ilas; v.mf = mf;
    v.cfg = cfg; v.data = data; v.err = err;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int steps;
    int len;
    int budget;

    i_frame_clk = 1'b0;
    i_lmfc_clk  = 1'b0;
    i_sync_n    = 1'b0;
    rst_n       = 1'b0;

    //   fr lm sn rn | st cgs ilas mf cfg data err
    add(1, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0);  // reset
    add(0, 1, 0, 1,   0, 1, 0, 0, 0, 0, 0);  // LMFC already high: no boundary
    add(1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0);  // FB with SYNC~ low: stay CGS
    add(0, 0, 1, 1,   0, 1, 0, 0, 0, 0, 0);  // SYNC~ high, no FB
    add(1, 0, 1, 1,   1, 1, 0, 0, 0, 0, 0);  // FB -> WAIT_LMFC
    add(0, 0, 1, 1,   1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1,   2, 0, 1, 0, 0, 0, 0);  // LB -> ILAS mf 0
    add(0, 1, 1, 1,   2, 0, 1, 0, 0, 0, 0);  // LMFC still high: no step
    add(1, 0, 1, 1,   2, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 1,   2, 0, 1, 1, 1, 0, 0);  // mf 1, config multiframe
    add(0, 0, 0, 1,   2, 0, 1, 1, 1, 0, 0);
    add(1, 0, 0, 1,   2, 0, 1, 1, 1, 0, 0);  // one low frame in ILAS
    add(0, 0, 1, 1,   2, 0, 1, 1, 1, 0, 0);  // short pulse in ILAS ignored
    add(0, 1, 1, 1,   2, 0, 1, 2, 0, 0, 0);
    add(0, 0, 1, 1,   2, 0, 1, 2, 0, 0, 0);
    add(0, 1, 1, 1,   2, 0, 1, 3, 0, 0, 0);
    add(0, 0, 1, 1,   2, 0, 1, 3, 0, 0, 0);
    add(0, 1, 1, 1,   3, 0, 0, 0, 0, 1, 0);  // last LB -> DATA
    add(1, 0, 0, 1,   3, 0, 0, 0, 0, 1, 0);  // one low frame in DATA
    add(0, 0, 1, 1,   3, 0, 0, 0, 0, 1, 1);  // rising: error report
    add(0, 0, 1, 1,   3, 0, 0, 0, 0, 1, 0);  // pulse lasts one cycle
    add(0, 0, 1, 0,   0, 1, 0, 0, 0, 0, 0);  // reset mid-DATA
    add(1, 1, 1, 1,   1, 1, 0, 0, 0, 0, 0);  // no LB right after reset
    add(0, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0);  // SYNC~ low in WAIT_LMFC
    add(1, 0, 1, 1,   1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1,   0, 1, 0, 0, 0, 0, 0);  // LB with SYNC~ low: CGS wins

    foreach (tbl[i]) begin
      step(tbl[i].fr, tbl[i].lm, tbl[i].sn, tbl[i].rn);
      chk($sformatf("vec%0d_state", i), o_state,       tbl[i].st);
      chk($sformatf("vec%0d_cgs",   i), o_cgs_en,      tbl[i].cgs);
      chk($sformatf("vec%0d_ilas",  i), o_ilas_en,     tbl[i].ilas);
      chk($sformatf("vec%0d_mf",    i), o_ilas_mf_idx, tbl[i].mf);
      chk($sformatf("vec%0d_cfg",   i), o_ilas_cfg_mf, tbl[i].cfg);
      chk($sformatf("vec%0d_data",  i), o_data_en,     tbl[i].data);
      chk($sformatf("vec%0d_err",   i), o_err_rpt,     tbl[i].err);
    end

    // Reset release with SYNC~ low, then bring the link up
    gcyc   = 0;
    sn_lvl = 1'b0;
    rn_lvl = 1'b0;
    gen_step();
    rn_lvl = 1'b1;
    repeat (10) gen_step();
    chk("hold_cgs_state", o_state, 0);
    chk("hold_cgs_en", o_cgs_en, 1);
    sn_lvl = 1'b1;
    run_until(1, 4, "reach_wait", n);
    chk("wait_latency_ok", n <= 2, 1);
    run_until(2, 16, "reach_ilas", n);
    run_until(3, 64, "reach_data", n);
    chk("ilas_len_clks", n, 32);

    // Short SYNC~ pulse in DATA: error report, stay in DATA
    sn_lvl = 1'b0;
    gen_frames(3);
    sn_lvl = 1'b1;
    gen_step();
    chk("short_pulse_err", o_err_rpt, 1);
    chk("short_pulse_state", o_state, 3);
`ifdef JESD_TX_ERR_CNT_EN
    chk("short_pulse_cnt", o_err_cnt, 1);
`endif
    gen_step();
    chk("short_pulse_once", o_err_rpt, 0);

    // Long SYNC~ low in DATA: resync on the 5th frame, no error report
    sn_lvl = 1'b0;
    gen_frames(4);
    chk("long_low_still_data", o_state, 3);
    gen_frames(1);
    chk("long_low_cgs", o_state, 0);
    chk("long_low_no_err", o_err_rpt, 0);
`ifdef JESD_TX_ERR_CNT_EN
    chk("long_low_cnt_clr", o_err_cnt, 0);
`endif

    // Resync during ILAS at mf 2, then relink restarts at mf 0
    sn_lvl = 1'b1;
    run_until(2, 40, "relink_ilas", n);
    budget = 0;
    while ((o_ilas_mf_idx !== 2'd2) && (budget < 40)) begin
      gen_step();
      budget++;
    end
    chk("reach_mf2", o_ilas_mf_idx, 2);
    sn_lvl = 1'b0;
    gen_frames(5);
    chk("ilas_resync_cgs", o_state, 0);
    sn_lvl = 1'b1;
    run_until(2, 40, "relink2_ilas", n);
    chk("relink_mf0", o_ilas_mf_idx, 0);

    // Single-cycle reset mid-DATA
    run_until(3, 80, "reach_data2", n);
    repeat (3) gen_step();
    rn_lvl = 1'b0;
    gen_step();
    chk("rst_state", o_state, 0);
    chk("rst_cgs", o_cgs_en, 1);
    chk("rst_ilas", o_ilas_en, 0);
    chk("rst_mf", o_ilas_mf_idx, 0);
    chk("rst_cfg", o_ilas_cfg_mf, 0);
    chk("rst_data", o_data_en, 0);
    chk("rst_err", o_err_rpt, 0);
    rn_lvl = 1'b1;

    // Random SYNC~ runs with occasional resets, checked by the model
    steps = 0;
    while (steps < 4000) begin
      sn_lvl = ($urandom_range(0, 9) < 6);
      len    = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) begin
        rn_lvl = ($urandom_range(0, 599) != 0);
        gen_step();
        steps++;
      end
    end
    rn_lvl = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
